// File: rtl/dmi_jtag_host_if.sv
// Request/response handshake between a debug requester and dmi_jtag_host.
interface dmi_jtag_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;

  modport master (
    output req_valid, req_addr, req_data, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_status
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_status
  );
endinterface

// File: rtl/dmi_jtag_host.sv
// JTAG host for a debug transport module: scans one DMI request through DMIACCESS,
// fetches its result with a NOP scan and retries through dtmcs.dmireset while busy.
module dmi_jtag_host #(
  parameter int unsigned         IrLength    = 5,
  parameter int unsigned         ClkDiv      = 2,
  parameter int unsigned         IdleCycles  = 4,
  parameter int unsigned         MaxRetries  = 3,
  parameter logic [IrLength-1:0] IrDtmcs     = IrLength'(5'h10),
  parameter logic [IrLength-1:0] IrDmiAccess = IrLength'(5'h11)
) (
  input  logic           clk_i,
  input  logic           trst_ni,
  dmi_jtag_host_if.slave dmi,
  output logic           tck_o,
  output logic           tms_o,
  output logic           tdi_o,
  input  logic           tdo_i,
  output logic           trst_no
);
  localparam int unsigned       DivW    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned       RetW    = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int unsigned       DmiW    = 41;
  localparam logic [DivW-1:0]   DivLast = DivW'(ClkDiv - 1);
  localparam logic [6:0]        IrLast  = 7'(4 + IrLength - 1);

  typedef enum logic [3:0] {
    TapReset, Idle, IrScan, DrReq, RunIdle, DrFetch, RstIr, RstDr, Respond
  } state_e;

  state_e                state_q, state_d;
  logic [6:0]            cnt_q, scan_len, dr_last;
  logic [DivW-1:0]       div_q;
  logic                  tck_run, tck_edge, tck_rise, tck_fall, last_step;
  logic                  ir_is_dmi_q, busy_retry;
  logic [RetW-1:0]       retries_q;
  logic [6:0]            addr_q;
  logic [31:0]           data_q;
  logic [1:0]            op_q;
  logic [DmiW-1:0]       cap_q, dr_val, dr_sh;
  logic [IrLength-1:0]   ir_sh;

  always_comb begin
    case (state_q)
      TapReset:       scan_len = 7'd6;
      IrScan, RstIr:  scan_len = 7'(IrLength + 6);
      DrReq, DrFetch: scan_len = 7'd46;
      RunIdle:        scan_len = 7'(IdleCycles);
      RstDr:          scan_len = 7'd37;
      default:        scan_len = 7'd1;
    endcase
  end

  assign tck_run    = (state_q != Idle) && (state_q != Respond);
  assign tck_edge   = tck_run && (div_q == DivLast);
  assign tck_rise   = tck_edge && !tck_o;
  assign tck_fall   = tck_edge && tck_o;
  assign last_step  = tck_fall && (cnt_q == scan_len - 7'd1);
  assign busy_retry = (cap_q[1:0] == 2'd3) && (retries_q < RetW'(MaxRetries));

  // TCK divider: every step of the scan sequence advances on a falling TCK edge
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      div_q   <= '0;
      tck_o   <= 1'b0;
      trst_no <= 1'b0;
    end else begin
      trst_no <= 1'b1;
      if (!tck_run) begin
        div_q <= '0;
        tck_o <= 1'b0;
      end else if (tck_edge) begin
        div_q <= '0;
        tck_o <= ~tck_o;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= TapReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (tck_fall) cnt_q <= last_step ? 7'd0 : cnt_q + 7'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TapReset: if (last_step) state_d = Idle;
      Idle:     if (dmi.req_valid) state_d = ir_is_dmi_q ? DrReq : IrScan;
      IrScan:   if (last_step) state_d = DrReq;
      DrReq:    if (last_step) state_d = RunIdle;
      RunIdle:  if (last_step) state_d = DrFetch;
      DrFetch:  if (last_step) state_d = busy_retry ? RstIr : Respond;
      RstIr:    if (last_step) state_d = RstDr;
      RstDr:    if (last_step) state_d = IrScan;
      Respond:  if (dmi.resp_ready) state_d = Idle;
      default:  state_d = TapReset;
    endcase
  end

  // Pin values are a pure function of (state, step), so they only move on falling TCK
  always_comb begin
    tms_o          = 1'b0;
    tdi_o          = 1'b0;
    dmi.req_ready  = 1'b0;
    dmi.resp_valid = 1'b0;
    ir_sh          = '0;
    dr_val         = '0;
    dr_sh          = '0;
    dr_last        = 7'd43;
    case (state_q)
      TapReset: tms_o = (cnt_q < 7'd5);
      Idle:     dmi.req_ready = 1'b1;
      IrScan, RstIr: begin
        ir_sh = ((state_q == RstIr) ? IrDtmcs : IrDmiAccess) >> (cnt_q - 7'd4);
        if (cnt_q < 7'd2) tms_o = 1'b1;
        else if (cnt_q < 7'd4) tms_o = 1'b0;
        else if (cnt_q <= IrLast) begin
          tdi_o = ir_sh[0];
          tms_o = (cnt_q == IrLast);
        end else tms_o = (cnt_q == IrLast + 7'd1);
      end
      DrReq, DrFetch, RstDr: begin
        case (state_q)
          DrReq:   dr_val = {addr_q, data_q, op_q};
          DrFetch: dr_val = {addr_q, data_q, 2'b00};
          default: dr_val = 41'h1_0000;
        endcase
        if (state_q == RstDr) dr_last = 7'd34;
        dr_sh = dr_val >> (cnt_q - 7'd3);
        if (cnt_q == 7'd0) tms_o = 1'b1;
        else if (cnt_q < 7'd3) tms_o = 1'b0;
        else if (cnt_q <= dr_last) begin
          tdi_o = dr_sh[0];
          tms_o = (cnt_q == dr_last);
        end else tms_o = (cnt_q == dr_last + 7'd1);
      end
      Respond:  dmi.resp_valid = 1'b1;
      default:  tms_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_is_dmi_q     <= 1'b0;
      retries_q       <= '0;
      dmi.resp_data   <= '0;
      dmi.resp_status <= '0;
    end else begin
      if (state_q == TapReset || state_q == RstIr) ir_is_dmi_q <= 1'b0;
      else if (state_q == IrScan && last_step)     ir_is_dmi_q <= 1'b1;
      if (state_q == Idle && dmi.req_valid) retries_q <= '0;
      else if (state_q == DrFetch && last_step && busy_retry) retries_q <= retries_q + 1'b1;
      // A reserved op code (1) is reported as a failure
      if (state_q == DrFetch && last_step && !busy_retry) begin
        dmi.resp_data   <= cap_q[33:2];
        dmi.resp_status <= (cap_q[1:0] == 2'd0) ? 2'd0 :
                           (cap_q[1:0] == 2'd3) ? 2'd3 : 2'd2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == Idle && dmi.req_valid) begin
      addr_q <= dmi.req_addr;
      data_q <= dmi.req_data;
      op_q   <= dmi.req_op;
    end
    if (tck_rise && (state_q == DrReq || state_q == DrFetch) &&
        cnt_q >= 7'd3 && cnt_q <= 7'd43)
      cap_q <= {tdo_i, cap_q[DmiW-1:1]};
  end
endmodule

// File: tb/tb_dmi_jtag_host.sv
// Bench for dmi_jtag_host: a behavioural TAP/DTM model on the JTAG pins and a
// response scoreboard fed from a table of DMI transactions.
module tb_dmi_jtag_host;
  localparam int         ClkDiv     = 2;
  localparam int         TckClk     = 2 * ClkDiv;
  localparam int         IdleCycles = 4;
  localparam logic [4:0] IrDtmcs    = 5'h10;
  localparam logic [4:0] IrDmi      = 5'h11;

  logic clk = 1'b0;
  logic trst_n = 1'b1;
  logic tck, tms, tdi, trst_tap_n;
  logic tdo = 1'b0;

  dmi_jtag_host_if dmi ();

  dmi_jtag_host #(
    .IrLength(5), .ClkDiv(ClkDiv), .IdleCycles(IdleCycles), .MaxRetries(3),
    .IrDtmcs(IrDtmcs), .IrDmiAccess(IrDmi)
  ) dut (
    .clk_i(clk), .trst_ni(trst_n), .dmi(dmi),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst_tap_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- TAP / DTM model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_e;

  tap_e        tap = TLR;
  logic [4:0]  ir = 5'h01;
  logic [4:0]  ir_sh = '0;
  logic [40:0] dmi_sh = '0;
  logic [40:0] last_req = '0;
  logic [31:0] cs_sh = '0;
  logic        byp = 1'b0;
  logic        pending = 1'b0;
  int          shift_cnt = 0;
  int          busy_given = 0;
  int          dmireset_cnt = 0;
  int          busy_limit = 0;
  logic [31:0] mdl_data = '0;
  logic [1:0]  mdl_status = '0;
  logic        tms_log[$];

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst_tap_n) begin
    if (!trst_tap_n) begin
      tap     <= TLR;
      ir      <= 5'h01;
      pending <= 1'b0;
    end else begin
      tms_log.push_back(tms);
      case (tap)
        TLR:  ir <= 5'h01;
        CIR:  ir_sh <= 5'b00001;
        SHIR: ir_sh <= {tdi, ir_sh[4:1]};
        UIR:  ir <= ir_sh;
        CDR: begin
          shift_cnt <= 0;
          if (ir == IrDmi) begin
            if (pending) begin
              pending <= 1'b0;
              if (busy_given < busy_limit) begin
                busy_given <= busy_given + 1;
                dmi_sh <= {last_req[40:34], mdl_data, 2'd3};
              end else begin
                dmi_sh <= {last_req[40:34], mdl_data, mdl_status};
              end
            end else dmi_sh <= '0;
          end else if (ir == IrDtmcs) cs_sh <= 32'h0000_0071;
          else byp <= 1'b0;
        end
        SHDR: begin
          shift_cnt <= shift_cnt + 1;
          if (ir == IrDmi) dmi_sh <= {tdi, dmi_sh[40:1]};
          else if (ir == IrDtmcs) cs_sh <= {tdi, cs_sh[31:1]};
          else byp <= tdi;
        end
        UDR: begin
          if (ir == IrDmi && dmi_sh[1:0] != 2'd0) begin
            last_req <= dmi_sh;
            pending  <= 1'b1;
          end else if (ir == IrDtmcs && cs_sh[16]) dmireset_cnt <= dmireset_cnt + 1;
        end
        default: ;
      endcase
      tap <= tap_next(tap, tms);
    end
  end

  always @(negedge tck or negedge trst_tap_n) begin
    if (!trst_tap_n) tdo <= 1'b0;
    else case (tap)
      SHDR:    tdo <= (ir == IrDmi) ? dmi_sh[0] : (ir == IrDtmcs) ? cs_sh[0] : byp;
      SHIR:    tdo <= ir_sh[0];
      default: tdo <= 1'b0;
    endcase
  end

  // ---------------- scoreboard and vectors ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          busy;
    logic [31:0] mdata;
    logic [1:0]  mstatus;
    logic [31:0] exp_data;
    logic [1:0]  exp_status;
    int          exp_tck;
    int          exp_resets;
    logic        fresh_ir;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [5:0] tms_pack(int base, int n);
    logic [5:0] r = '0;
    for (int i = 0; i < n; i++)
      r = {r[4:0], (base + i < tms_log.size()) ? tms_log[base + i] : 1'bx};
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_tck"},         64'(tck), 64'd0);
    check({tag, "_tms"},         64'(tms), 64'd1);
    check({tag, "_tdi"},         64'(tdi), 64'd0);
    check({tag, "_trst_no"},     64'(trst_tap_n), 64'd0);
    check({tag, "_req_ready"},   64'(dmi.req_ready), 64'd0);
    check({tag, "_resp_valid"},  64'(dmi.resp_valid), 64'd0);
    check({tag, "_resp_data"},   64'(dmi.resp_data), 64'd0);
    check({tag, "_resp_status"}, 64'(dmi.resp_status), 64'd0);
  endtask

  task automatic release_reset(input string tag, output logic saw_resp);
    int cyc;
    int base;
    saw_resp = 1'b0;
    @(negedge clk);
    base   = tms_log.size();
    trst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, "_trst_no_rise"}, 64'(trst_tap_n), 64'd1);
    cyc = 1;
    while (!dmi.req_ready && cyc < 200) begin
      saw_resp |= dmi.resp_valid;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_ready_clk"}, 64'(cyc), 64'd24);
    check({tag, "_tapreset_tms"}, 64'(tms_pack(base, 6)), 64'b111110);
    check({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    int   cyc;
    int   base;
    int   rst0;
    e.data   = v.exp_data;
    e.status = v.exp_status;
    sb.push_back(e);
    mdl_data   = v.mdata;
    mdl_status = v.mstatus;
    busy_limit = busy_given + v.busy;
    rst0       = dmireset_cnt;
    @(negedge clk);
    n = 0;
    while (!dmi.req_ready && n < 1000) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 64'(dmi.req_ready), 64'd1);
    dmi.req_addr  = v.addr;
    dmi.req_data  = v.data;
    dmi.req_op    = v.op;
    dmi.req_valid = 1'b1;
    @(posedge clk);
    base = tms_log.size();
    #1 dmi.req_valid = 1'b0;
    cyc = 0;
    while (!dmi.resp_valid && cyc < 4000) begin @(posedge clk); #1; cyc++; end
    check({tag, "_latency_clk"}, 64'(cyc), 64'(v.exp_tck * TckClk));
    if (dmi.resp_valid && sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, "_resp_data"},   64'(dmi.resp_data), 64'(got.data));
      check({tag, "_resp_status"}, 64'(dmi.resp_status), 64'(got.status));
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 64'(dmi.resp_valid), 64'd1);
      check({tag, "_hold_data"},  64'({dmi.resp_data, dmi.resp_status}), 64'({got.data, got.status}));
    end else begin
      check({tag, "_resp_seen"}, 64'(dmi.resp_valid), 64'd1);
    end
    check({tag, "_first_tms"}, 64'(tms_pack(base, 3)), v.fresh_ir ? 64'b110 : 64'b100);
    check({tag, "_ir"}, 64'(ir), 64'(IrDmi));
    check({tag, "_dmiresets"}, 64'(dmireset_cnt - rst0), 64'(v.exp_resets));
    check({tag, "_request"}, 64'(last_req), 64'({v.addr, v.data, v.op}));
    @(negedge clk);
    dmi.resp_ready = 1'b1;
    @(posedge clk); #1;
    dmi.resp_ready = 1'b0;
    check({tag, "_resp_drop"}, 64'(dmi.resp_valid), 64'd0);
    check({tag, "_back_idle"}, 64'(dmi.req_ready), 64'd1);
  endtask

  initial begin
    logic saw_resp;
    int   n;
    // op, addr, data, busy, model data, model status, exp data, exp status, TCKs, resets, fresh IR
    vecs[0] = '{2'd1, 7'h11, 32'h0,         0, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF, 2'd0, 107, 0, 1'b1};
    vecs[1] = '{2'd2, 7'h04, 32'h1,         0, 32'h00000001, 2'd0, 32'h00000001, 2'd0,  96, 0, 1'b0};
    vecs[2] = '{2'd1, 7'h20, 32'h0,         1, 32'hCAFEF00D, 2'd0, 32'hCAFEF00D, 2'd0, 251, 1, 1'b0};
    vecs[3] = '{2'd1, 7'h05, 32'h0,         4, 32'h12345678, 2'd0, 32'h12345678, 2'd3, 561, 3, 1'b0};
    vecs[4] = '{2'd2, 7'h3F, 32'hA5A55A5A,  0, 32'h00000000, 2'd2, 32'h00000000, 2'd2,  96, 0, 1'b0};
    vecs[5] = '{2'd1, 7'h7F, 32'h0,         0, 32'h0BADF00D, 2'd1, 32'h0BADF00D, 2'd2,  96, 0, 1'b0};
    vecs[6] = '{2'd1, 7'h11, 32'h0,         0, 32'h00000042, 2'd0, 32'h00000042, 2'd0, 107, 0, 1'b1};

    dmi.req_valid  = 1'b0;
    dmi.req_addr   = '0;
    dmi.req_data   = '0;
    dmi.req_op     = '0;
    dmi.resp_ready = 1'b0;

    #2 trst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    release_reset("boot", saw_resp);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset pulse while bit 20 of a request is on the wire
    busy_limit    = busy_given;
    @(negedge clk);
    dmi.req_addr  = 7'h2A;
    dmi.req_data  = 32'h5555AAAA;
    dmi.req_op    = 2'd2;
    dmi.req_valid = 1'b1;
    @(posedge clk);
    #1 dmi.req_valid = 1'b0;
    n = 0;
    while (!(tap == SHDR && shift_cnt == 20) && n < 2000) begin @(negedge clk); n++; end
    check("midreq_reached_bit20", 64'(shift_cnt), 64'd20);
    trst_n = 1'b0;
    #1;
    check_reset_values("midreq");
    repeat (3) @(posedge clk);
    release_reset("midreq", saw_resp);
    check("midreq_no_response", 64'(saw_resp | dmi.resp_valid), 64'd0);
    check("midreq_sb_empty", 64'(sb.size()), 64'd0);

    do_txn(vecs[6], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
